// File: rtl/led_pwm_ctrl_pkg.sv
// Shared encodings and register field positions for the LED PWM controller.
package led_pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_e;

    localparam int CTRL_ADDR      = 0;
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 16;
    localparam int PRESC_W        = 16;

    localparam int CH_MODE_LSB = 0;
    localparam int CH_DUTY_LSB = 8;
    localparam int CH_HALF_LSB = 16;
    localparam int HALF_W      = 8;

    // HALF=0 behaves like HALF=1, so the blink counter never has to reach -1.
    function automatic logic [HALF_W-1:0] blink_limit(input logic [HALF_W-1:0] half);
        return (half == '0) ? '0 : half - 8'd1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: CHn register, blink counter/state and registered output mux.
module led_channel
    import led_pwm_ctrl_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_wr,
    input  mode_e             i_mode,
    input  logic [PWM_W-1:0]  i_duty,
    input  logic [HALF_W-1:0] i_half,
    input  logic [PWM_W-1:0]  i_pwm_cnt,
    input  logic              i_period,
    output logic              o_led,
    output logic [31:0]       o_rdata
);

    mode_e             r_mode;
    logic [PWM_W-1:0]  r_duty;
    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_blink_cnt;
    logic              r_blink;
    logic              r_led;
    logic              w_led_next;

    // A write restarts the blink phase, and takes priority over a coincident strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_OFF;
            r_duty      <= '0;
            r_half      <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (i_wr) begin
            r_mode      <= i_mode;
            r_duty      <= i_duty;
            r_half      <= i_half;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (!i_en) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (i_period) begin
            if (r_blink_cnt == blink_limit(r_half)) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_led_next = 1'b0;
        case (r_mode)
            MODE_ON:    w_led_next = 1'b1;
            MODE_BLINK: w_led_next = r_blink;
            MODE_PWM:   w_led_next = (i_pwm_cnt < r_duty);
            default:    w_led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= i_en && w_led_next;
        end
    end

    always_comb begin
        o_rdata                         = '0;
        o_rdata[CH_MODE_LSB +: 2]       = r_mode;
        o_rdata[CH_DUTY_LSB +: PWM_W]   = r_duty;
        o_rdata[CH_HALF_LSB +: HALF_W]  = r_half;
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Register-programmed LED controller: request/response port, shared prescaled
// PWM timebase and NUM_LEDS independent off/on/blink/PWM channels.
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PWM_W    = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic [NUM_LEDS-1:0] led
);

    state_e               r_state;
    logic                 r_req_ready;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_rdata;
    logic                 r_en;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   r_presc_cnt;
    logic [PWM_W-1:0]     r_pwm_cnt;

    logic                 w_accept;
    logic                 w_wr;
    logic                 w_tick;
    logic                 w_period;
    logic [31:0]          w_rdata;
    logic [31:0]          w_ch_rdata [NUM_LEDS];
    logic                 w_unused_wdata;

    assign w_accept = req_valid && r_req_ready;
    assign w_wr     = w_accept && req_we;
    assign w_tick   = r_en && (r_presc_cnt == r_presc);
    assign w_period = w_tick && (&r_pwm_cnt);

    // Not every write-data bit maps to a register field.
    assign w_unused_wdata = ^req_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state      <= ST_RESP;
                        r_req_ready  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= req_we ? 32'd0 : w_rdata;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en    <= 1'b0;
            r_presc <= '0;
        end else if (w_wr && (req_addr == ADDR_W'(CTRL_ADDR))) begin
            r_en    <= req_wdata[CTRL_EN_BIT];
            r_presc <= req_wdata[CTRL_PRESC_LSB +: PRESC_W];
        end
    end

    // A prescaler already past a newly lowered PRESC wraps without ticking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else if (!r_en) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_presc_cnt <= (r_presc_cnt >= r_presc) ? '0 : r_presc_cnt + 16'd1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (r_en),
            .i_wr      (w_wr && (req_addr == ADDR_W'(g + 1))),
            .i_mode    (mode_e'(req_wdata[CH_MODE_LSB +: 2])),
            .i_duty    (req_wdata[CH_DUTY_LSB +: PWM_W]),
            .i_half    (req_wdata[CH_HALF_LSB +: HALF_W]),
            .i_pwm_cnt (r_pwm_cnt),
            .i_period  (w_period),
            .o_led     (led[g]),
            .o_rdata   (w_ch_rdata[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (req_addr == ADDR_W'(CTRL_ADDR)) begin
            w_rdata[CTRL_EN_BIT]                 = r_en;
            w_rdata[CTRL_PRESC_LSB +: PRESC_W]   = r_presc;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (req_addr == ADDR_W'(i + 1)) begin
                w_rdata = w_ch_rdata[i];
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Randomized bench for led_pwm_ctrl against a tick/period-count reference model.
module tb_led_pwm_ctrl;

    localparam int NUM_LEDS = 4;
    localparam int PWM_W    = 8;
    localparam int ADDR_W   = 4;
    localparam int P        = 1 << PWM_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_we = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [31:0]         req_wdata = '0;
    logic                req_ready;
    logic                resp_valid;
    logic [31:0]         resp_rdata;
    logic [NUM_LEDS-1:0] led;

    led_pwm_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_W    (PWM_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .led        (led)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the timebase is a running tick count since enable;
    // PWM position and period index fall out of it by division/modulo.
    bit                  m_en;
    int                  m_presc;
    int                  m_pcnt;
    int                  m_ticks;
    int                  m_mode [NUM_LEDS];
    int                  m_duty [NUM_LEDS];
    int                  m_half [NUM_LEDS];
    int                  m_base [NUM_LEDS];
    bit                  m_busy;
    bit                  e_resp;
    logic [31:0]         e_rdata;
    logic [NUM_LEDS-1:0] e_led;

    task automatic model_reset();
        m_en = 0; m_presc = 0; m_pcnt = 0; m_ticks = 0;
        m_busy = 0; e_resp = 0; e_rdata = '0; e_led = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            m_mode[i] = 0; m_duty[i] = 0; m_half[i] = 0; m_base[i] = 0;
        end
    endtask

    function automatic int m_blink(input int i);
        int periods;
        int h;
        periods = m_ticks / P;
        h = (m_half[i] == 0) ? 1 : m_half[i];
        return ((periods - m_base[i]) / h) % 2;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        if (a == 0) begin
            r[0] = m_en;
            v = m_presc;
            r[31:16] = v[15:0];
        end else if (a <= NUM_LEDS) begin
            v = m_mode[a-1];  r[1:0]   = v[1:0];
            v = m_duty[a-1];  r[8 +: PWM_W] = v[PWM_W-1:0];
            v = m_half[a-1];  r[23:16] = v[7:0];
        end
        return r;
    endfunction

    // Advance the model across one clock edge, then compare just after the edge.
    task automatic cycle();
        logic [NUM_LEDS-1:0] nl;
        logic [31:0]         wd;
        bit                  acc;
        bit                  v;
        int                  a;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (m_mode[i])
                1:       v = 1'b1;
                2:       v = (m_blink(i) == 1);
                3:       v = ((m_ticks % P) < m_duty[i]);
                default: v = 1'b0;
            endcase
            nl[i] = m_en && v;
        end
        acc = req_valid && !m_busy;
        a   = int'(req_addr);
        wd  = req_wdata;
        if (m_busy) begin
            m_busy = 0; e_resp = 0; e_rdata = '0;
        end else if (acc) begin
            m_busy = 1; e_resp = 1;
            e_rdata = req_we ? 32'd0 : m_read(a);
        end
        if (m_en) begin
            if (m_pcnt == m_presc) m_ticks++;
            m_pcnt = (m_pcnt >= m_presc) ? 0 : m_pcnt + 1;
        end else begin
            m_pcnt = 0; m_ticks = 0;
            for (int i = 0; i < NUM_LEDS; i++) m_base[i] = 0;
        end
        if (acc && req_we) begin
            if (a == 0) begin
                m_en = wd[0];
                m_presc = int'(wd[31:16]);
            end else if (a <= NUM_LEDS) begin
                m_mode[a-1] = int'(wd[1:0]);
                m_duty[a-1] = int'(wd[8 +: PWM_W]);
                m_half[a-1] = int'(wd[23:16]);
                m_base[a-1] = m_ticks / P;
            end
        end
        e_led = nl;
        @(posedge clk);
        #1;
        check("led", 32'(led), 32'(e_led));
        check("req_ready", 32'(req_ready), 32'(!m_busy));
        check("resp_valid", 32'(resp_valid), 32'(e_resp));
        check("resp_rdata", resp_rdata, e_rdata);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic bus(input bit we, input int addr, input logic [31:0] data);
        int guard;
        guard = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = data;
        while (m_busy && guard < 4) begin
            cycle();
            guard++;
        end
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic measure_toggle(input int b, output int per);
        logic prev;
        int   n;
        prev = led[b]; n = 0;
        while (led[b] == prev && n < 2000) begin cycle(); n++; end
        prev = led[b]; n = 0;
        while (led[b] == prev && n < 2000) begin cycle(); n++; end
        per = n;
    endtask

    initial begin
        int          cnt;
        int          per;
        int          a;
        bit          we;
        logic [31:0] d;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) bus(1'b0, i, 32'd0);
        idle(1);

        bus(1'b1, 0, 32'h1);
        bus(1'b1, 1, 32'h1);
        idle(1);
        check("on_led0", 32'(led[0]), 32'd1);
        bus(1'b1, 1, 32'h0);
        idle(1);
        check("off_led0", 32'(led[0]), 32'd0);

        bus(1'b1, 2, 32'h0000_4003);
        idle(4);
        cnt = 0;
        repeat (256) begin cycle(); cnt += int'(led[1]); end
        check("pwm_duty64", cnt, 64);
        bus(1'b1, 2, 32'h0000_0003);
        idle(2);
        cnt = 0;
        repeat (256) begin cycle(); cnt += int'(led[1]); end
        check("pwm_duty0", cnt, 0);
        bus(1'b1, 2, 32'h0000_FF03);
        idle(2);
        cnt = 0;
        repeat (256) begin cycle(); cnt += int'(led[1]); end
        check("pwm_duty255", cnt, 255);

        bus(1'b1, 3, 32'h0002_0002);
        measure_toggle(2, per);
        check("blink_half2", per, 512);
        bus(1'b1, 3, 32'h0000_0002);
        measure_toggle(2, per);
        check("blink_half0", per, 256);

        bus(1'b1, 0, 32'h0);
        idle(3);
        check("disable_led", 32'(led), 32'd0);
        bus(1'b1, 0, 32'h1);
        idle(600);

        idle(1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
        cnt = 0;
        repeat (6) begin cycle(); cnt += int'(resp_valid); end
        req_valid = 1'b0;
        check("hs_accepts", cnt, 3);
        idle(1);

        bus(1'b0, 15, 32'd0);
        check("oob_valid", 32'(resp_valid), 32'd1);
        check("oob_rdata", resp_rdata, 32'd0);
        bus(1'b1, 15, 32'hFFFF_FFFF);
        idle(2);

        for (int k = 0; k < 200; k++) begin
            a  = int'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (a == 0) begin
                d[31:16] = 16'($urandom_range(0, 3));
                d[0]     = ($urandom_range(0, 7) != 0);
            end else begin
                d[23:16] = 8'($urandom_range(0, 3));
            end
            bus(we, a, d);
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(300, 800)));
            else idle(int'($urandom_range(0, 20)));
        end

        bus(1'b1, 0, 32'h1);
        bus(1'b1, 1, 32'h1);
        idle(3);
        bus(1'b0, 1, 32'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_led", 32'(led), 32'd0);
        check("rstmid_rdata", resp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= NUM_LEDS; i++) begin
            bus(1'b0, i, 32'd0);
            check("rstmid_reg_cleared", resp_rdata, 32'd0);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
